rtc_inicializacion: RTL and testbench

Power-up initialization sequencer for the parallel-bus RTC controller. On a start request it copies N_REGS (register-address, value) pairs from the init ROM into the shared RAM. It then replays each pair onto the RTC multiplexed bus as a write cycle: address phase, then data phase. It only drives control strobes, addresses and mux selects; the datapath muxes live outside this block.

---
 rtl/rtc_inicializacion_if.sv | 30 +++
 rtl/rtc_inicializacion.sv | 104 ++++++++++
 tb/tb_rtc_inicializacion.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_inicializacion_if.sv
// Bus bundle between the RTC init sequencer and the ROM/RAM/RTC datapath.
// The sequencer uses the slave view; whoever requests the run uses master.
interface rtc_inicializacion_if;
    logic        do_it_inic;
    logic        rom_to_ram;
    logic [17:0] dir_rom;
    logic        rom_enable;
    logic        rtc_to_ram;
    logic        ram_to_rtc;
    logic        a_d;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [31:0] dir_ram;
    logic        w_ram_enable;
    logic        r_ram_enable;
    logic [6:0]  Contador;

    modport master (
        output do_it_inic,
        input  rom_to_ram, dir_rom, rom_enable, rtc_to_ram, ram_to_rtc,
               a_d, cs, rd, wr, dir_ram, w_ram_enable, r_ram_enable, Contador
    );

    modport slave (
        input  do_it_inic,
        output rom_to_ram, dir_rom, rom_enable, rtc_to_ram, ram_to_rtc,
               a_d, cs, rd, wr, dir_ram, w_ram_enable, r_ram_enable, Contador
    );
endinterface

// File: rtl/rtc_inicializacion.sv
// RTC power-up sequencer: copies ROM (addr,value) pairs into RAM, then replays
// each pair as an RTC bus write. Define INIC_RETRIGGER_EN to allow DONE -> IDLE.
module rtc_inicializacion #(
    parameter int          N_REGS   = 4,
    parameter logic [17:0] ROM_BASE = 18'h0,
    parameter logic [31:0] RAM_BASE = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    rtc_inicializacion_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] IDX_LAST = 5'(N_REGS - 1);
    localparam logic [6:0] CNT_LAST = 7'd21;

    state_t     state, state_nx;
    logic [4:0] idx, idx_nx;
    logic [6:0] cnt, cnt_nx;
    logic [17:0] pair_rom;
    logic [31:0] pair_ram;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Slot base word 2*i, widened to each address bus before adding the base
    assign pair_rom = {12'd0, idx, 1'b0};
    assign pair_ram = {26'd0, idx, 1'b0};

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;

        bus.rom_to_ram   = 1'b0;
        bus.dir_rom      = '0;
        bus.rom_enable   = 1'b0;
        bus.rtc_to_ram   = 1'b0;
        bus.ram_to_rtc   = 1'b0;
        bus.a_d          = 1'b1;
        bus.cs           = 1'b1;
        bus.rd           = 1'b1;
        bus.wr           = 1'b1;
        bus.dir_ram      = '0;
        bus.w_ram_enable = 1'b0;
        bus.r_ram_enable = 1'b0;
        bus.Contador     = cnt;

        case (state)
            IDLE: begin
                if (bus.do_it_inic) begin
                    state_nx = RUN;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (idx == IDX_LAST) state_nx = DONE;
                    else                 idx_nx   = idx + 5'd1;
                end else begin
                    cnt_nx = cnt + 7'd1;
                end

                if (cnt <= 7'd1) begin
                    // ROM -> RAM copy: reg address word, then value word
                    bus.rom_enable   = 1'b1;
                    bus.rom_to_ram   = 1'b1;
                    bus.w_ram_enable = 1'b1;
                    bus.dir_rom      = ROM_BASE + pair_rom + {17'd0, cnt[0]};
                    bus.dir_ram      = RAM_BASE + pair_ram + {31'd0, cnt[0]};
                end else begin
                    bus.r_ram_enable = 1'b1;
                    bus.ram_to_rtc   = 1'b1;
                    if (cnt <= 7'd11) begin
                        bus.a_d     = 1'b0;
                        bus.dir_ram = RAM_BASE + pair_ram;
                    end else begin
                        bus.a_d     = 1'b1;
                        bus.dir_ram = RAM_BASE + pair_ram + 32'd1;
                    end
                    bus.cs = !((cnt >= 7'd3 && cnt <= 7'd10) || (cnt >= 7'd13 && cnt <= 7'd20));
                    bus.wr = !((cnt >= 7'd4 && cnt <= 7'd9)  || (cnt >= 7'd14 && cnt <= 7'd19));
                end
            end
            DONE: begin
`ifdef INIC_RETRIGGER_EN
                if (!bus.do_it_inic) state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rtc_inicializacion.sv
// Self-checking bench for rtc_inicializacion against a run-level step model.
module tb_rtc_inicializacion;
    localparam int N_REGS  = 4;
    localparam int RUN_LEN = 22 * N_REGS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_inicializacion_if bus();

    rtc_inicializacion #(
        .N_REGS  (N_REGS),
        .ROM_BASE(18'h0),
        .RAM_BASE(32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model: phase 0 idle, 1 running, 2 done; mt = clocks elapsed in the run
    int mph = 0;
    int mt  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mph <= 0;
            mt  <= 0;
        end else begin
            case (mph)
                0: if (bus.do_it_inic) begin mph <= 1; mt <= 0; end
                1: if (mt == RUN_LEN - 1) begin mph <= 2; mt <= 0; end
                   else mt <= mt + 1;
                default: begin
`ifdef INIC_RETRIGGER_EN
                    if (!bus.do_it_inic) mph <= 0;
`endif
                end
            endcase
        end
    end

    function automatic logic [66:0] obs_vec();
        return {bus.rom_to_ram, bus.dir_rom, bus.rom_enable, bus.rtc_to_ram,
                bus.ram_to_rtc, bus.a_d, bus.cs, bus.rd, bus.wr, bus.dir_ram,
                bus.w_ram_enable, bus.r_ram_enable, bus.Contador};
    endfunction

    function automatic logic [66:0] exp_vec();
        logic [17:0] drom = '0;
        logic [31:0] dram = '0;
        logic r2r = 0, ren = 0, r2t = 0, ad = 1, cs_n = 1, wr_n = 1, wen = 0, rren = 0;
        logic [6:0] c7 = '0;
        int slot, c, off;
        if (mph == 1) begin
            slot = mt / 22;
            c    = mt % 22;
            c7   = 7'(c);
            if (c < 2) begin
                r2r = 1; ren = 1; wen = 1;
                drom = 18'(2 * slot + c);
                dram = 32'(2 * slot + c);
            end else begin
                rren = 1; r2t = 1;
                ad   = (c >= 12);
                dram = 32'(2 * slot + ((c >= 12) ? 1 : 0));
                off  = (c < 12) ? c - 2 : c - 12;
                cs_n = !(off >= 1 && off <= 8);
                wr_n = !(off >= 2 && off <= 7);
            end
        end
        return {r2r, drom, ren, 1'b0, r2t, ad, cs_n, 1'b1, wr_n, dram, wen, rren, c7};
    endfunction

    task automatic test_reset();
        bus.do_it_inic = 1'b1;
        #1 reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full_run();
        int falls = 0;
        logic prev_wr = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < RUN_LEN + 110; k++) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL full_run k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            if (prev_wr && !bus.wr) falls++;
            prev_wr = bus.wr;
            if (k == 2) bus.do_it_inic = 1'b0;
        end
        tests++;
        if (falls !== 2 * N_REGS) begin
            fails++;
            $display("FAIL full_run_wr_pulses got=%0d want=%0d", falls, 2 * N_REGS);
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) begin reset = 1'b1; bus.do_it_inic = 1'b1; end
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL abort_pre got=%h want=%h", obs_vec(), exp_vec());
            end
            if (bus.Contador == 7'd15 && bus.dir_ram == 32'd3) found = 1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_reach got=timeout want=slot1_cnt15");
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus.wr, bus.cs} !== 2'b11 || obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL abort_async got=%h want=%h", obs_vec(), exp_vec());
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.dir_rom !== 18'd0 || bus.Contador !== 7'd0 || bus.rom_enable !== 1'b1) begin
            fails++;
            $display("FAIL restart got=rom%0d cnt%0d en%b want=rom0 cnt0 en1",
                     bus.dir_rom, bus.Contador, bus.rom_enable);
        end
        bus.do_it_inic = 1'b0;
        repeat (RUN_LEN + 5) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL restart_run got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_retrigger();
        int falls = 0;
        int want;
        logic prev_wr = 1'b1;
`ifdef INIC_RETRIGGER_EN
        want = 2 * N_REGS;
`else
        want = 0;
`endif
        bus.do_it_inic = 1'b0;
        repeat (3) @(negedge clk);
        bus.do_it_inic = 1'b1;
        repeat (RUN_LEN + 20) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL retrigger got=%h want=%h", obs_vec(), exp_vec());
            end
            if (prev_wr && !bus.wr) falls++;
            prev_wr = bus.wr;
        end
        tests++;
        if (falls !== want) begin
            fails++;
            $display("FAIL retrigger_pulses got=%0d want=%0d", falls, want);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            bus.do_it_inic = ($urandom % 4) == 0;
            if (($urandom % 150) == 0) begin
                #($urandom_range(1, 3)) reset = 1'b0;
                #1;
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL random_reset got=%h want=%h", obs_vec(), exp_vec());
                end
                @(negedge clk) reset = 1'b1;
            end
        end
    endtask

    initial begin
        bus.do_it_inic = 1'b0;
        test_reset();
        test_full_run();
        test_abort();
        test_retrigger();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
